// File: rtl/cim_core_reg_file.sv
// ----------------------------------------------------------------------------
// cim_core_reg_file
//
// Memory-mapped control/status register block for a compute-in-memory core.
// A simple valid/ready register bus programs the operation configuration
// (source, destination, length), launches the core with a one-cycle start
// pulse, and collects the core's done/error completion pulses into sticky
// status bits that can raise a level interrupt.
//
// Register map (byte offsets, only addr[4:2] decoded):
//   0x00 CTRL      b0 START (W1, self-clear), b1 SOFT_CLR (W1, self-clear),
//                  b2 IRQ_EN (RW)
//   0x04 STATUS    b0 BUSY (RO), b1 DONE (W1C), b2 ERR (W1C)
//   0x08 SRC_ADDR  RW
//   0x0C DST_ADDR  RW
//   0x10 LEN       RW, LEN_WIDTH bits
//   0x14 CYCLE_CNT RO (only when CIM_CORE_REG_PERF_EN is defined,
//                  otherwise the offset is unmapped)
//   0x18 ID        RO, returns ID_VALUE
//
// Parameters:
//   ID_VALUE    value returned by the ID register
//   LEN_WIDTH   width of the LEN register and len_o
//
// Ports:
//   clk_i, rst_i               single clock, synchronous active-high reset
//   reg_valid_i/reg_write_i    bus request (held until ready), 1 = write
//   reg_addr_i/reg_wdata_i     byte address and write data
//   reg_wstrb_i                byte write strobes
//   reg_rdata_o/reg_ready_o    read data and transfer acknowledge
//   reg_error_o                transfer error, valid with ready
//   start_o                    one-cycle operation start pulse to the core
//   src_addr_o/dst_addr_o      operation source/destination addresses
//   len_o                      operation length
//   done_i/err_i               core completion / error pulses
//   irq_o                      level interrupt IRQ_EN & (DONE | ERR)
//
// Build option:
//   CIM_CORE_REG_PERF_EN       when defined, adds the saturating CYCLE_CNT
//                              busy-cycle counter at 0x14.
// ----------------------------------------------------------------------------
module cim_core_reg_file #(
    parameter logic [31:0] ID_VALUE  = 32'hC1A0_0001,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [31:0]          reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_ready_o,
    output logic                 reg_error_o,
    output logic                 start_o,
    output logic [31:0]          src_addr_o,
    output logic [31:0]          dst_addr_o,
    output logic [LEN_WIDTH-1:0] len_o,
    input  logic                 done_i,
    input  logic                 err_i,
    output logic                 irq_o
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_SRC    = 3'd2;
    localparam logic [2:0] OFF_DST    = 3'd3;
    localparam logic [2:0] OFF_LEN    = 3'd4;
    localparam logic [2:0] OFF_CNT    = 3'd5;
    localparam logic [2:0] OFF_ID     = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic                 irq_en_q, irq_en_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic                 err_q,    err_d;
    logic                 start_q,  start_d;
    logic [31:0]          src_q,    src_d;
    logic [31:0]          dst_q,    dst_d;
    logic [LEN_WIDTH-1:0] len_q,    len_d;

    logic [2:0]  offset;
    logic        in_ack;
    logic        wr_en;
    logic        bad_access;
    logic [31:0] read_val;
    logic [31:0] len_ext;
    logic [31:0] len_merged;
    logic        start_req;
    logic        soft_clr_req;
    logic        start_ok;
    logic        start_rej;
    logic        commit;

    // Address bits outside [4:2] are intentionally ignored by the decoder.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_addr_i[31:5], reg_addr_i[1:0]};

    // Byte-lane merge used by every RW register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign offset = reg_addr_i[4:2];
    assign in_ack = (state_q == ACK);
    assign wr_en  = in_ack & reg_write_i;

    always_comb begin
        len_ext                = '0;
        len_ext[LEN_WIDTH-1:0] = len_q;
    end

`ifdef CIM_CORE_REG_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
`endif

    // Bus FSM: a request seen in IDLE is acknowledged in the following ACK
    // cycle, which gives every transfer a fixed two-cycle minimum.
    always_comb begin
        state_d     = state_q;
        reg_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (reg_valid_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                reg_ready_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux and access legality. Writes to read-only registers and any
    // access to an unmapped offset are rejected without side effects.
    always_comb begin
        read_val   = '0;
        bad_access = 1'b0;
        case (offset)
            OFF_CTRL:   read_val = {29'd0, irq_en_q, 2'b00};
            OFF_STATUS: read_val = {29'd0, err_q, done_q, busy_q};
            OFF_SRC:    read_val = src_q;
            OFF_DST:    read_val = dst_q;
            OFF_LEN:    read_val = len_ext;
            OFF_CNT: begin
`ifdef CIM_CORE_REG_PERF_EN
                read_val   = cycle_cnt_q;
                bad_access = reg_write_i;
`else
                bad_access = 1'b1;
`endif
            end
            OFF_ID: begin
                read_val   = ID_VALUE;
                bad_access = reg_write_i;
            end
            default: bad_access = 1'b1;
        endcase
    end

    // SOFT_CLR wins over a START written in the same word; a START that
    // arrives while busy is dropped and flagged, but the rest of the CTRL
    // write still lands.
    assign start_req    = wr_en & (offset == OFF_CTRL) & reg_wdata_i[0] & reg_wstrb_i[0];
    assign soft_clr_req = wr_en & (offset == OFF_CTRL) & reg_wdata_i[1] & reg_wstrb_i[0];
    assign start_ok     = start_req & ~soft_clr_req & ~busy_q;
    assign start_rej    = start_req & ~soft_clr_req &  busy_q;
    assign commit       = wr_en & ~bad_access;

    // Bus response: data and error are only driven while acknowledging.
    always_comb begin
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        if (in_ack) begin
            reg_error_o = bad_access | start_rej;
            if (!reg_write_i && !bad_access) begin
                reg_rdata_o = read_val;
            end
        end
    end

    // Configuration registers, written per byte lane.
    assign len_merged = merge_bytes(len_ext, reg_wdata_i, reg_wstrb_i);

    always_comb begin
        irq_en_d = irq_en_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        if (commit) begin
            case (offset)
                OFF_CTRL: if (reg_wstrb_i[0]) irq_en_d = reg_wdata_i[2];
                OFF_SRC:  src_d = merge_bytes(src_q, reg_wdata_i, reg_wstrb_i);
                OFF_DST:  dst_d = merge_bytes(dst_q, reg_wdata_i, reg_wstrb_i);
                OFF_LEN:  len_d = len_merged[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Operation status. Ordering encodes priority: a core done/err pulse
    // overrides a same-cycle W1C clear, and SOFT_CLR overrides everything.
    always_comb begin
        start_d = start_ok;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start_ok) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (commit && (offset == OFF_STATUS) && reg_wstrb_i[0]) begin
            if (reg_wdata_i[1]) done_d = 1'b0;
            if (reg_wdata_i[2]) err_d  = 1'b0;
        end
        if (busy_q && done_i) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (busy_q && err_i) begin
            busy_d = 1'b0;
            err_d  = 1'b1;
        end
        if (soft_clr_req) begin
            busy_d = 1'b0;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            irq_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
        end
    end

`ifdef CIM_CORE_REG_PERF_EN
    // Busy-cycle counter: restarts on an accepted START, saturates at max.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (busy_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (start_ok || soft_clr_req) begin
            cycle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end
`endif

    assign start_o    = start_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign len_o      = len_q;
    assign irq_o      = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_cim_core_reg_file.sv
// ----------------------------------------------------------------------------
// tb_cim_core_reg_file
//
// Self-checking bench for cim_core_reg_file. Each bus transfer pushes its
// expected response onto a scoreboard queue; the scenario task pops it once
// the DUT acknowledges and compares it inline. Inputs change at the falling
// edge or 1 time unit after the rising edge; outputs are sampled likewise.
// ----------------------------------------------------------------------------
module tb_cim_core_reg_file;

    localparam logic [31:0] ID_VAL = 32'hC1A0_0001;

    logic        clk;
    logic        rst_i;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;
    logic        reg_error_o;
    logic        start_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [15:0] len_o;
    logic        done_i;
    logic        err_i;
    logic        irq_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks;
    int          n_fails;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_lat;

    cim_core_reg_file dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ready_o (reg_ready_o),
        .reg_error_o (reg_error_o),
        .start_o     (start_o),
        .src_addr_o  (src_addr_o),
        .dst_addr_o  (dst_addr_o),
        .len_o       (len_o),
        .done_i      (done_i),
        .err_i       (err_i),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bus transfer: pushes the expected response, drives the request,
    // waits (bounded) for ready and captures the response. Optionally
    // pulses done_i during the acknowledge cycle.
    task automatic bus_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic pulse_done);
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
        obs_lat = 0;
        do begin
            @(negedge clk);
            obs_lat++;
        end while (!reg_ready_o && obs_lat < 8);
        if (!reg_ready_o) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL ready_timeout: addr=%h got no ready after %0d cycles, expected ready", addr, obs_lat);
        end
        obs_rdata = reg_rdata_o;
        obs_err   = reg_error_o;
        if (pulse_done) done_i = 1'b1;
        @(posedge clk);
        #1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        done_i      = 1'b0;
    endtask

    task automatic pulse_core(input logic d, input logic er);
        @(negedge clk);
        done_i = d;
        err_i  = er;
        @(negedge clk);
        done_i = 1'b0;
        err_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({reg_ready_o, reg_error_o, reg_rdata_o, start_o, irq_o} !== 36'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got ready=%0b err=%0b rdata=%h start=%0b irq=%0b, expected all 0",
                     reg_ready_o, reg_error_o, reg_rdata_o, start_o, irq_o);
        end
        rst_i = 1'b0;
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL reset_status: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL reset_src: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h18, 32'h0, 4'h0, ID_VAL, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL reset_id: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_strobe();
        bus_xfer(1'b1, 32'h08, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL wr_src_strb: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (obs_lat !== 1) begin n_fails++; $display("[TB] FAIL ready_latency: got %0d cycles, expected 1", obs_lat); end
        bus_xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_5678, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_src_strb: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (src_addr_o !== 32'h0000_5678) begin n_fails++; $display("[TB] FAIL src_addr_o: got %h, expected 00005678", src_addr_o); end
        bus_xfer(1'b1, 32'h0C, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b1, 32'h0C, 32'h1122_3344, 4'b1000, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b0, 32'h0C, 32'h0, 4'h0, 32'h11FE_F00D, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_dst_merge: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (dst_addr_o !== 32'h11FE_F00D) begin n_fails++; $display("[TB] FAIL dst_addr_o: got %h, expected 11fef00d", dst_addr_o); end
        bus_xfer(1'b1, 32'h10, 32'hABCD_1234, 4'b1111, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_len: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (len_o !== 16'h1234) begin n_fails++; $display("[TB] FAIL len_o: got %h, expected 1234", len_o); end
    endtask

    task automatic test_start_done();
        bus_xfer(1'b1, 32'h00, 32'h5, 4'b0001, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL wr_ctrl_start: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (start_o !== 1'b1) begin n_fails++; $display("[TB] FAIL start_pulse: got %0b, expected 1", start_o); end
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL status_busy: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (start_o !== 1'b0) begin n_fails++; $display("[TB] FAIL start_one_cycle: got %0b, expected 0", start_o); end
        // Busy for cycles 1..10 after the START commit; done in cycle 10.
        repeat (7) @(posedge clk);
        #1 done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h2, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL status_done: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (irq_o !== 1'b1) begin n_fails++; $display("[TB] FAIL irq_done: got %0b, expected 1", irq_o); end
`ifdef CIM_CORE_REG_PERF_EN
        bus_xfer(1'b0, 32'h14, 32'h0, 4'h0, 32'd10, 1'b0, 1'b0);
`else
        bus_xfer(1'b0, 32'h14, 32'h0, 4'h0, 32'd0, 1'b1, 1'b0);
`endif
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL cycle_cnt: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_start_busy();
        bus_xfer(1'b1, 32'h00, 32'h5, 4'b0001, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL restart: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fails++; $display("[TB] FAIL irq_after_restart: got %0b, expected 0", irq_o); end
        bus_xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h4, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_ctrl_irqen: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h00, 32'h1, 4'b0001, 32'h0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL start_while_busy: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (start_o !== 1'b0) begin n_fails++; $display("[TB] FAIL start_busy_pulse: got %0b, expected 0", start_o); end
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL busy_kept: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL irqen_committed: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_w1c_race();
        bus_xfer(1'b1, 32'h04, 32'h2, 4'b0001, 32'h0, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h2, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL done_beats_w1c: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h04, 32'h2, 4'b0001, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL w1c_done: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h00, 32'h1, 4'b0001, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        pulse_core(1'b0, 1'b1);
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h4, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL status_err: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fails++; $display("[TB] FAIL irq_masked: got %0b, expected 0", irq_o); end
        pulse_core(1'b1, 1'b0);
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h4, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL done_ignored_idle: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h04, 32'h4, 4'b0001, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL w1c_err: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_soft_clr();
        bus_xfer(1'b1, 32'h00, 32'h5, 4'b0001, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        bus_xfer(1'b1, 32'h00, 32'h6, 4'b0001, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL wr_soft_clr: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL soft_clr_status: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h4, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL soft_clr_irqen: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_5678, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL soft_clr_src: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h00, 32'h7, 4'b0001, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL start_and_clr: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        n_checks++;
        if (start_o !== 1'b0) begin n_fails++; $display("[TB] FAIL start_dropped: got %0b, expected 0", start_o); end
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL start_and_clr_status: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_unmapped();
        bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_unmapped: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL wr_id: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h18, 32'h0, 4'h0, ID_VAL, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL id_kept: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b1, 32'h14, 32'h5, 4'hF, 32'h0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL wr_cnt: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
`ifdef CIM_CORE_REG_PERF_EN
        bus_xfer(1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
`else
        bus_xfer(1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
`endif
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL rd_cnt: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h28, 32'h0, 4'h0, 32'h0000_5678, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL addr_alias: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_reset_in_ack();
        bus_xfer(1'b1, 32'h00, 32'h5, 4'b0001, 32'h0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        pulse_core(1'b1, 1'b0);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fails++; $display("[TB] FAIL irq_before_reset: got %0b, expected 1", irq_o); end
        @(negedge clk);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 32'h08;
        reg_wdata_i = 32'hAAAA_BBBB;
        reg_wstrb_i = 4'hF;
        @(negedge clk);
        n_checks++;
        if (reg_ready_o !== 1'b1) begin n_fails++; $display("[TB] FAIL ack_before_reset: got ready=%0b, expected 1", reg_ready_o); end
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({reg_ready_o, reg_error_o, reg_rdata_o, start_o, irq_o} !== 36'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ack: got ready=%0b err=%0b rdata=%h start=%0b irq=%0b, expected all 0",
                     reg_ready_o, reg_error_o, reg_rdata_o, start_o, irq_o);
        end
        @(negedge clk);
        rst_i       = 1'b0;
        reg_write_i = 1'b0;
        n_checks++;
        if ({src_addr_o, dst_addr_o, len_o} !== 80'd0) begin n_fails++; $display("[TB] FAIL reset_cfg_ports: got src=%h dst=%h len=%h, expected 0", src_addr_o, dst_addr_o, len_o); end
        bus_xfer(1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL no_commit_src: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL reset_status2: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
        bus_xfer(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin n_fails++; $display("[TB] FAIL reset_ctrl2: got err=%0b rdata=%h, expected err=%0b rdata=%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        done_i      = 1'b0;
        err_i       = 1'b0;
        $display("[TB] starting cim_core_reg_file bench");
        test_reset();
        test_strobe();
        test_start_done();
        test_start_busy();
        test_w1c_race();
        test_soft_clr();
        test_unmapped();
        test_reset_in_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
